// File: rtl/snake_pkg.sv
// Shared constants, direction/state encodings and helpers for the snake body.
// Defining SNAKE_WRAP_EN makes the head wrap at the playfield edge instead of hitting a wall.
package snake_pkg;

  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;
  localparam int CELL    = 10;
  localparam int MAX_LEN = 16;

  localparam logic [7:0] X_LAST = 8'(XSCREEN - CELL);
  localparam logic [6:0] Y_LAST = 7'(YSCREEN - CELL);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_DONE
  } state_t;

  // Opposite headings differ in both encoding bits.
  function automatic logic isOpposite(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b11;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator: resolves the effective heading and the moved head cell.
// Edge behaviour (wrap or out-of-field flag) follows snake_pkg::WRAP_EN, set by SNAKE_WRAP_EN.
module snake_next_head
  import snake_pkg::*;
(
  input  logic [7:0] i_headX,
  input  logic [6:0] i_headY,
  input  logic [1:0] i_dir,
  input  logic [1:0] i_heading,
  output logic [7:0] o_newX,
  output logic [6:0] o_newY,
  output logic [1:0] o_newHeading,
  output logic       o_outOfField
);

  logic [1:0] w_move;

  assign w_move       = isOpposite(i_dir, i_heading) ? i_heading : i_dir;
  assign o_newHeading = w_move;

  // At the edge the head either wraps to the far side or stays put and flags the wall.
  always_comb begin
    o_newX       = i_headX;
    o_newY       = i_headY;
    o_outOfField = 1'b0;
    case (w_move)
      DIR_RIGHT:
        if (i_headX >= X_LAST) begin
          if (WRAP_EN) o_newX = 8'd0;
          else o_outOfField = 1'b1;
        end else o_newX = i_headX + 8'(CELL);
      DIR_LEFT:
        if (i_headX == 8'd0) begin
          if (WRAP_EN) o_newX = X_LAST;
          else o_outOfField = 1'b1;
        end else o_newX = i_headX - 8'(CELL);
      DIR_DOWN:
        if (i_headY >= Y_LAST) begin
          if (WRAP_EN) o_newY = 7'd0;
          else o_outOfField = 1'b1;
        end else o_newY = i_headY + 7'(CELL);
      default:
        if (i_headY == 7'd0) begin
          if (WRAP_EN) o_newY = Y_LAST;
          else o_outOfField = 1'b1;
        end else o_newY = i_headY - 7'(CELL);
    endcase
  end

endmodule

// File: rtl/snake_body.sv
// Snake body store: shifts segments on each step, then scans the body for a head collision.
// Playfield edge handling is selected by SNAKE_WRAP_EN (see snake_pkg / snake_next_head).
module snake_body #(
  parameter int         MAX_LEN  = 16,
  parameter int         INIT_LEN = 4,
  parameter logic [7:0] INIT_X   = 8'd70,
  parameter logic [6:0] INIT_Y   = 7'd60
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       init,
  input  logic       step,
  input  logic [1:0] dir,
  input  logic       grow,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_x,
  output logic [6:0] rd_y,
  output logic [4:0] length,
  output logic       busy,
  output logic       done,
  output logic       collide,
  output logic       wall_hit
);
  import snake_pkg::*;

  localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);
  localparam logic [4:0] LEN_INIT = 5'(INIT_LEN);

  state_t     r_state, w_nextState;
  logic [7:0] r_segX [MAX_LEN];
  logic [6:0] r_segY [MAX_LEN];
  logic [4:0] r_length;
  logic [1:0] r_heading, r_dirReq;
  logic       r_growReq;
  logic [3:0] r_chkIdx;
  logic       r_collide, r_wallHit;

  logic [7:0] w_newX;
  logic [6:0] w_newY;
  logic [1:0] w_newHeading;
  logic       w_outOfField;
  logic [4:0] w_lenAfter;
  logic       w_lastChk;

  snake_next_head u_nextHead (
    .i_headX      (r_segX[0]),
    .i_headY      (r_segY[0]),
    .i_dir        (r_dirReq),
    .i_heading    (r_heading),
    .o_newX       (w_newX),
    .o_newY       (w_newY),
    .o_newHeading (w_newHeading),
    .o_outOfField (w_outOfField)
  );

  assign w_lenAfter = (r_growReq && (r_length < LEN_MAX)) ? r_length + 5'd1 : r_length;
  assign w_lastChk  = ({1'b0, r_chkIdx} + 5'd1) >= r_length;

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || init) r_state <= S_IDLE;
    else r_state <= w_nextState;
  end

  // A blocked move or a body too short to self-intersect skips the collision scan.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (step) w_nextState = S_SHIFT;
      S_SHIFT: w_nextState = (w_outOfField || (w_lenAfter < 5'd2)) ? S_DONE : S_CHECK;
      S_CHECK: if (w_lastChk) w_nextState = S_DONE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_segX[i] <= 8'd0;
        r_segY[i] <= 7'd0;
      end
      r_length  <= 5'd0;
      r_heading <= DIR_RIGHT;
      r_dirReq  <= DIR_RIGHT;
      r_growReq <= 1'b0;
      r_chkIdx  <= 4'd1;
      r_collide <= 1'b0;
      r_wallHit <= 1'b0;
    end else if (init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_segX[i] <= 8'(int'(INIT_X) - i * CELL);
        r_segY[i] <= INIT_Y;
      end
      r_length  <= LEN_INIT;
      r_heading <= DIR_RIGHT;
      r_growReq <= 1'b0;
      r_chkIdx  <= 4'd1;
      r_collide <= 1'b0;
      r_wallHit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (step) begin
            r_dirReq  <= dir;
            r_growReq <= grow;
          end
        S_SHIFT: begin
          r_heading <= w_newHeading;
          r_chkIdx  <= 4'd1;
          if (w_outOfField) r_wallHit <= 1'b1;
          else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              r_segX[i] <= r_segX[i-1];
              r_segY[i] <= r_segY[i-1];
            end
            r_segX[0] <= w_newX;
            r_segY[0] <= w_newY;
            r_length  <= w_lenAfter;
          end
        end
        S_CHECK: begin
          if ((r_segX[r_chkIdx] == r_segX[0]) && (r_segY[r_chkIdx] == r_segY[0])) r_collide <= 1'b1;
          r_chkIdx <= r_chkIdx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign rd_x     = r_segX[rd_idx];
  assign rd_y     = r_segY[rd_idx];
  assign length   = r_length;
  assign collide  = r_collide;
  assign wall_hit = r_wallHit;

endmodule

// File: tb/tb_snake_body.sv
// Directed self-checking bench for snake_body; expectations follow SNAKE_WRAP_EN when defined.
module tb_snake_body;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic       init     = 1'b0;
  logic       step     = 1'b0;
  logic [1:0] dir      = 2'b00;
  logic       grow     = 1'b0;
  logic [3:0] rd_idx   = 4'd0;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [4:0] length;
  logic       busy, done, collide, wall_hit;

  int checks = 0;
  int errors = 0;
  logic busyFirst;

  snake_body dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .init     (init),
    .step     (step),
    .dir      (dir),
    .grow     (grow),
    .rd_idx   (rd_idx),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .collide  (collide),
    .wall_hit (wall_hit)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkSeg(input string tag, input int idx, input int ex, input int ey);
    rd_idx = 4'(idx);
    #1;
    checkOutput({tag, ".x"}, int'(rd_x), ex);
    checkOutput({tag, ".y"}, int'(rd_y), ey);
  endtask

  task automatic doInit();
    @(negedge CLOCK_50);
    init = 1'b1;
    @(negedge CLOCK_50);
    init = 1'b0;
  endtask

  // One step pulse; latency counted in cycles after the sampling edge until done.
  task automatic applyStimulus(input logic [1:0] d, input logic g, input int expLat, input string tag);
    int n;
    @(negedge CLOCK_50);
    step = 1'b1;
    dir  = d;
    grow = g;
    @(negedge CLOCK_50);
    step = 1'b0;
    grow = 1'b0;
    n = 1;
    busyFirst = busy;
    while (!done && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    checkOutput({tag, ".lat"}, n, expLat);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge CLOCK_50);
    Resetn = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("rst.len", int'(length), 0);
    checkOutput("rst.busy", int'(busy), 0);
    checkOutput("rst.done", int'(done), 0);
    checkOutput("rst.collide", int'(collide), 0);
    checkOutput("rst.wall", int'(wall_hit), 0);
    checkSeg("rst.seg0", 0, 0, 0);
    checkSeg("rst.seg5", 5, 0, 0);

    doInit();
    checkOutput("init.len", int'(length), 4);
    checkSeg("init.seg0", 0, 70, 60);
    checkSeg("init.seg1", 1, 60, 60);
    checkSeg("init.seg2", 2, 50, 60);
    checkSeg("init.seg3", 3, 40, 60);
    checkOutput("init.collide", int'(collide), 0);
    checkOutput("init.wall", int'(wall_hit), 0);
    checkOutput("init.busy", int'(busy), 0);

    applyStimulus(2'b00, 1'b0, 5, "stepR");
    checkOutput("stepR.busy", int'(busyFirst), 1);
    checkSeg("stepR.head", 0, 80, 60);
    checkSeg("stepR.seg3", 3, 50, 60);
    checkOutput("stepR.collide", int'(collide), 0);
    checkOutput("stepR.len", int'(length), 4);

    doInit();
    applyStimulus(2'b11, 1'b0, 5, "rev");
    checkSeg("rev.head", 0, 80, 60);
    checkSeg("rev.seg1", 1, 70, 60);

    doInit();
    @(negedge CLOCK_50);
    step = 1'b1;
    dir  = 2'b00;
    @(negedge CLOCK_50);
    step = 1'b0;
    @(negedge CLOCK_50);
    step = 1'b1;
    dir  = 2'b01;
    @(negedge CLOCK_50);
    step = 1'b0;
    dir  = 2'b00;
    n = 0;
    while (!done && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    checkOutput("ignBusy.doneSeen", int'(done), 1);
    repeat (4) @(negedge CLOCK_50);
    checkOutput("ignBusy.idle", int'(busy), 0);
    checkSeg("ignBusy.head", 0, 80, 60);

    doInit();
    applyStimulus(2'b00, 1'b1, 6, "grow");
    checkOutput("grow.len", int'(length), 5);
    checkSeg("grow.seg4", 4, 40, 60);
    checkSeg("grow.head", 0, 80, 60);
    applyStimulus(2'b01, 1'b0, 6, "down");
    checkOutput("down.collide", int'(collide), 0);
    applyStimulus(2'b11, 1'b0, 6, "left");
    checkOutput("left.collide", int'(collide), 0);
    checkSeg("left.head", 0, 70, 70);
    applyStimulus(2'b10, 1'b0, 6, "up");
    checkOutput("up.collide", int'(collide), 1);
    checkSeg("up.head", 0, 70, 60);

    @(negedge CLOCK_50);
    step = 1'b1;
    dir  = 2'b10;
    @(negedge CLOCK_50);
    step = 1'b0;
    @(negedge CLOCK_50);
    checkSeg("midChk.head", 0, 70, 50);
    checkOutput("midChk.busy", int'(busy), 1);
    init = 1'b1;
    @(negedge CLOCK_50);
    init = 1'b0;
    checkOutput("midChk.busy0", int'(busy), 0);
    checkOutput("midChk.collide", int'(collide), 0);
    checkOutput("midChk.len", int'(length), 4);
    checkSeg("midChk.seg0", 0, 70, 60);
    checkSeg("midChk.seg3", 3, 40, 60);
    @(negedge CLOCK_50);
    checkOutput("midChk.noDone", int'(done), 0);

    doInit();
    for (int i = 0; i < 8; i++) applyStimulus(2'b00, 1'b0, 5, "toEdge");
    checkSeg("edge.head", 0, 150, 60);
`ifdef SNAKE_WRAP_EN
    applyStimulus(2'b00, 1'b0, 5, "wrap");
    checkOutput("wrap.wall", int'(wall_hit), 0);
    checkSeg("wrap.head", 0, 0, 60);
    checkSeg("wrap.seg1", 1, 150, 60);
`else
    applyStimulus(2'b00, 1'b0, 2, "wall");
    checkOutput("wall.wall", int'(wall_hit), 1);
    checkSeg("wall.head", 0, 150, 60);
    checkSeg("wall.seg1", 1, 140, 60);
    checkOutput("wall.len", int'(length), 4);
    applyStimulus(2'b01, 1'b0, 5, "wallSticky");
    checkOutput("wallSticky.wall", int'(wall_hit), 1);
    checkSeg("wallSticky.head", 0, 150, 70);
`endif
    doInit();
    checkOutput("reinit.wall", int'(wall_hit), 0);

    for (int i = 0; i < 8; i++) applyStimulus(2'b00, 1'b1, 6 + i, "satR");
    for (int i = 0; i < 4; i++) applyStimulus(2'b01, 1'b1, 14 + i, "satD");
    checkOutput("sat.len16", int'(length), 16);
    applyStimulus(2'b01, 1'b1, 17, "satMax");
    checkOutput("satMax.len", int'(length), 16);
    checkSeg("satMax.head", 0, 150, 110);
    checkSeg("satMax.seg15", 15, 50, 60);
    checkOutput("satMax.collide", int'(collide), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
